// File: rtl/i2c_pkg.sv
// rtl/i2c_pkg.sv - shared state encoding and default timing limits for the I2C arbiter
package i2c_pkg;

    typedef enum logic [2:0] {
        IDLE   = 3'd0,
        LATCH  = 3'd1,
        LAUNCH = 3'd2,
        BUSY   = 3'd3,
        DONE   = 3'd4,
        ABORT  = 3'd5
    } state_e;

    localparam int DEF_TMO_CYC    = 4096;
    localparam int DEF_LAUNCH_CYC = 8;

endpackage

// File: rtl/rr_arb2.sv
// rtl/rr_arb2.sv - two-way round-robin pick with a pointer that moves to the loser
module rr_arb2 (
    input  logic clk,
    input  logic rst,
    input  logic req0,
    input  logic req1,
    input  logic upd,
    input  logic last_win,
    output logic pick
);

    logic ptr_q, ptr_d;

    // Pointer hands priority to whoever did not win the finished transaction
    always_comb begin
        ptr_d = ptr_q;
        if (upd) begin
            ptr_d = ~last_win;
        end
    end

    // Pointer register, starts favouring requester 0
    always_ff @(posedge clk) begin
        if (!rst) begin
            ptr_q <= 1'b0;
        end else begin
            ptr_q <= ptr_d;
        end
    end

    // Contention resolved by the pointer; a lone requester always wins
    always_comb begin
        pick = 1'b0;
        if (req0 && req1) begin
            pick = ptr_q;
        end else if (req1) begin
            pick = 1'b1;
        end
    end

endmodule

// File: rtl/i2c_arb.sv
// rtl/i2c_arb.sv - two-requester arbiter in front of a single I2C master
module i2c_arb
    import i2c_pkg::*;
#(
    parameter int TMO_CYC    = DEF_TMO_CYC,
    parameter int LAUNCH_CYC = DEF_LAUNCH_CYC
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        req0,
    input  logic        req1,
    input  logic        rw0,
    input  logic        rw1,
    input  logic [6:0]  addr0,
    input  logic [6:0]  addr1,
    input  logic [31:0] din0,
    input  logic [31:0] din1,
    input  logic [1:0]  bcnt0,
    input  logic [1:0]  bcnt1,
    output logic        gnt0,
    output logic        gnt1,
    output logic        done0,
    output logic        done1,
    output logic        err0,
    output logic        err1,
    output logic        m_enable,
    output logic        m_rw,
    output logic [6:0]  m_addr,
    output logic [31:0] m_din,
    output logic [1:0]  m_bytcount,
    input  logic        m_ready
);

    localparam int MAXC = (TMO_CYC > LAUNCH_CYC) ? TMO_CYC : LAUNCH_CYC;
    localparam int CW   = $clog2(MAXC) + 1;
    localparam logic [CW-1:0] TMO_LIM    = CW'(TMO_CYC - 1);
    localparam logic [CW-1:0] LAUNCH_LIM = CW'(LAUNCH_CYC - 1);
    localparam logic [CW-1:0] CNT_MAX    = '1;

    state_e        state_q, state_d;
    logic [CW-1:0] cnt_q, cnt_d;
    logic          win_q, win_d;
    logic          m_rw_q, m_rw_d;
    logic [6:0]    m_addr_q, m_addr_d;
    logic [31:0]   m_din_q, m_din_d;
    logic [1:0]    m_bytcount_q, m_bytcount_d;
    logic          pick;
    logic          ptr_upd;
    logic          gnt_act;

    rr_arb2 u_rr (
        .clk      (clk),
        .rst      (rst),
        .req0     (req0),
        .req1     (req1),
        .upd      (ptr_upd),
        .last_win (win_q),
        .pick     (pick)
    );

    // Next state, wait counter and master command capture
    always_comb begin
        state_d      = state_q;
        win_d        = win_q;
        m_rw_d       = m_rw_q;
        m_addr_d     = m_addr_q;
        m_din_d      = m_din_q;
        m_bytcount_d = m_bytcount_q;
        cnt_d        = (cnt_q != CNT_MAX) ? cnt_q + 1'b1 : cnt_q;
        case (state_q)
            IDLE: begin
                if ((req0 || req1) && m_ready) begin
                    state_d      = LATCH;
                    win_d        = pick;
                    m_rw_d       = pick ? rw1 : rw0;
                    m_addr_d     = pick ? addr1 : addr0;
                    m_din_d      = pick ? din1 : din0;
                    m_bytcount_d = pick ? bcnt1 : bcnt0;
                end
            end
            LATCH:  state_d = LAUNCH;
            LAUNCH: begin
                if (!m_ready) begin
                    state_d = BUSY;
                end else if (cnt_q >= LAUNCH_LIM) begin
                    state_d = ABORT;
                end
            end
            BUSY: begin
                if (m_ready) begin
                    state_d = DONE;
                end else if (cnt_q >= TMO_LIM) begin
                    state_d = ABORT;
                end
            end
            DONE:    state_d = IDLE;
            ABORT:   state_d = IDLE;
            default: state_d = IDLE;
        endcase
        // Every state starts its wait window from zero
        if (state_d != state_q) begin
            cnt_d = '0;
        end
    end

    // State and captured command registers
    always_ff @(posedge clk) begin
        if (!rst) begin
            state_q      <= IDLE;
            cnt_q        <= '0;
            win_q        <= 1'b0;
            m_rw_q       <= 1'b0;
            m_addr_q     <= '0;
            m_din_q      <= '0;
            m_bytcount_q <= '0;
        end else begin
            state_q      <= state_d;
            cnt_q        <= cnt_d;
            win_q        <= win_d;
            m_rw_q       <= m_rw_d;
            m_addr_q     <= m_addr_d;
            m_din_q      <= m_din_d;
            m_bytcount_q <= m_bytcount_d;
        end
    end

    assign gnt_act    = (state_q == LATCH) || (state_q == LAUNCH) || (state_q == BUSY);
    assign ptr_upd    = (state_q == DONE) || (state_q == ABORT);
    assign gnt0       = gnt_act && !win_q;
    assign gnt1       = gnt_act && win_q;
    assign done0      = (state_q == DONE) && !win_q;
    assign done1      = (state_q == DONE) && win_q;
    assign err0       = (state_q == ABORT) && !win_q;
    assign err1       = (state_q == ABORT) && win_q;
    assign m_enable   = (state_q == LAUNCH);
    assign m_rw       = m_rw_q;
    assign m_addr     = m_addr_q;
    assign m_din      = m_din_q;
    assign m_bytcount = m_bytcount_q;

endmodule

// File: tb/tb_i2c_arb.sv
// tb/tb_i2c_arb.sv - self-checking bench for the I2C arbiter
module tb_i2c_arb;

    localparam int TMO  = 16;
    localparam int LCYC = 8;

    typedef struct {
        int          first_gnt;
        int          en_cnt;
        int          busy_cyc;
        logic [15:0] pulses;
        bit          overlap;
        bit          timed_out;
        bit          gnt_at_pulse;
        logic [31:0] din;
        logic [6:0]  addr;
        logic        rw;
        logic [1:0]  bcnt;
    } obs_t;

    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic        req0 = 1'b0, req1 = 1'b0, rw0 = 1'b0, rw1 = 1'b0;
    logic [6:0]  addr0 = '0, addr1 = '0;
    logic [31:0] din0 = '0, din1 = '0;
    logic [1:0]  bcnt0 = '0, bcnt1 = '0;
    logic        m_ready = 1'b1;
    logic        gnt0, gnt1, done0, done1, err0, err1;
    logic        m_enable, m_rw;
    logic [6:0]  m_addr;
    logic [31:0] m_din;
    logic [1:0]  m_bytcount;

    int vectors = 0;
    int errors  = 0;
    int ptr_m   = 0;

    always #5 clk = ~clk;

    i2c_arb #(.TMO_CYC(TMO), .LAUNCH_CYC(LCYC)) dut (
        .clk(clk), .rst(rst),
        .req0(req0), .req1(req1), .rw0(rw0), .rw1(rw1),
        .addr0(addr0), .addr1(addr1), .din0(din0), .din1(din1),
        .bcnt0(bcnt0), .bcnt1(bcnt1),
        .gnt0(gnt0), .gnt1(gnt1), .done0(done0), .done1(done1),
        .err0(err0), .err1(err1),
        .m_enable(m_enable), .m_rw(m_rw), .m_addr(m_addr), .m_din(m_din),
        .m_bytcount(m_bytcount), .m_ready(m_ready)
    );

    // Reference outcome: launch succeeds if the master reacts within LCYC
    // enable cycles; busy phase lasts as long as m_ready stays low, capped at TMO.
    function automatic bit model_ok(input int lw, input int bl);
        return (lw <= LCYC) && (bl <= TMO);
    endfunction

    function automatic int model_winner(input logic r0, input logic r1, input int ptr);
        if (r0 && r1) return ptr;
        return r1 ? 1 : 0;
    endfunction

    function automatic logic [15:0] model_pulses(input bit ok, input int win);
        logic [15:0] p;
        p = '0;
        if (ok && win == 0)  p[15:12] = 4'd1;
        if (ok && win == 1)  p[11:8]  = 4'd1;
        if (!ok && win == 0) p[7:4]   = 4'd1;
        if (!ok && win == 1) p[3:0]   = 4'd1;
        return p;
    endfunction

    function automatic void randomize_data();
        rw0   = 1'($urandom_range(0, 1));
        rw1   = 1'($urandom_range(0, 1));
        addr0 = 7'($urandom);
        addr1 = 7'($urandom);
        din0  = $urandom;
        din1  = $urandom;
        bcnt0 = 2'($urandom_range(0, 3));
        bcnt1 = 2'($urandom_range(0, 3));
    endfunction

    // Plays the master side for one transaction and records what the arbiter did
    task automatic do_txn(input int launch_wait, input int busy_len, input bit drop_on_gnt,
                          output obs_t o);
        int low_left;
        bit finished;
        low_left       = 0;
        finished       = 0;
        o.first_gnt    = -1;
        o.en_cnt       = 0;
        o.busy_cyc     = 0;
        o.pulses       = '0;
        o.overlap      = 0;
        o.timed_out    = 1;
        o.gnt_at_pulse = 0;
        o.din          = '0;
        o.addr         = '0;
        o.rw           = 1'b0;
        o.bcnt         = '0;
        for (int cyc = 0; cyc < 300; cyc++) begin
            @(posedge clk);
            #1;
            if (gnt0 && gnt1) o.overlap = 1;
            if ((done0 || done1) && (err0 || err1)) o.overlap = 1;
            if ((done0 && done1) || (err0 && err1)) o.overlap = 1;
            o.pulses[15:12] = o.pulses[15:12] + {3'b0, done0};
            o.pulses[11:8]  = o.pulses[11:8]  + {3'b0, done1};
            o.pulses[7:4]   = o.pulses[7:4]   + {3'b0, err0};
            o.pulses[3:0]   = o.pulses[3:0]   + {3'b0, err1};
            if (finished) begin
                o.timed_out = 0;
                break;
            end
            if (o.first_gnt < 0 && (gnt0 || gnt1)) begin
                o.first_gnt = gnt1 ? 1 : 0;
                if (drop_on_gnt) begin
                    if (gnt1) req1 = 1'b0;
                    else      req0 = 1'b0;
                end
            end
            if ((gnt0 || gnt1) && !m_enable && o.en_cnt > 0) o.busy_cyc++;
            if (low_left > 0 && !m_ready) begin
                low_left--;
                if (low_left == 0) m_ready = 1'b1;
            end
            if (m_enable) begin
                if (o.en_cnt == 0) begin
                    o.din  = m_din;
                    o.addr = m_addr;
                    o.rw   = m_rw;
                    o.bcnt = m_bytcount;
                end
                o.en_cnt++;
                if (o.en_cnt == launch_wait) begin
                    m_ready  = 1'b0;
                    low_left = busy_len;
                end
            end
            if (done0 || done1 || err0 || err1) begin
                o.gnt_at_pulse = gnt0 || gnt1;
                finished = 1;
                m_ready  = 1'b1;
                low_left = 0;
                if (done0 || err0) req0 = 1'b0;
                if (done1 || err1) req1 = 1'b0;
            end
        end
        m_ready = 1'b1;
    endtask

    task automatic test_reset();
        rst = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        vectors++;
        if ({gnt0, gnt1, done0, done1, err0, err1, m_enable, m_rw} !== 8'h00) begin
            errors++;
            $display("FAIL reset_ctrl got %b exp 00000000", {gnt0, gnt1, done0, done1, err0, err1, m_enable, m_rw});
        end
        vectors++;
        if ({m_addr, m_din, m_bytcount} !== 41'd0) begin
            errors++;
            $display("FAIL reset_data got addr %h din %h bcnt %0d exp 0", m_addr, m_din, m_bytcount);
        end
        rst   = 1'b1;
        ptr_m = 0;
    endtask

    task automatic test_alternation();
        obs_t o;
        int   exp_seq [3];
        exp_seq = '{0, 1, 0};
        randomize_data();
        req0 = 1'b1;
        req1 = 1'b1;
        for (int k = 0; k < 3; k++) begin
            do_txn(1, 2, 1'b0, o);
            vectors++;
            if (o.first_gnt !== exp_seq[k]) begin
                errors++;
                $display("FAIL alternation_%0d got gnt%0d exp gnt%0d", k, o.first_gnt, exp_seq[k]);
            end
            vectors++;
            if (o.pulses !== model_pulses(1, exp_seq[k]) || o.overlap || o.timed_out) begin
                errors++;
                $display("FAIL alternation_pulse_%0d got %h ovl %0d tmo %0d exp %h", k, o.pulses, o.overlap, o.timed_out, model_pulses(1, exp_seq[k]));
            end
            ptr_m = 1 - exp_seq[k];
            req0 = 1'b1;
            req1 = 1'b1;
        end
        req0 = 1'b0;
        req1 = 1'b0;
    endtask

    task automatic test_single_write();
        obs_t o;
        rw0 = 1'b0; addr0 = 7'h50; din0 = 32'hA1B2C3D4; bcnt0 = 2'd3;
        req0 = 1'b1;
        do_txn(1, 3, 1'b0, o);
        vectors++;
        if (o.first_gnt !== 0 || o.en_cnt !== 1 || o.busy_cyc !== 3) begin
            errors++;
            $display("FAIL single_timing got gnt%0d en %0d busy %0d exp gnt0 en 1 busy 3", o.first_gnt, o.en_cnt, o.busy_cyc);
        end
        vectors++;
        if (o.pulses !== 16'h1000 || o.gnt_at_pulse || o.timed_out) begin
            errors++;
            $display("FAIL single_done got %h gnt %0d tmo %0d exp 1000", o.pulses, o.gnt_at_pulse, o.timed_out);
        end
        vectors++;
        if ({o.rw, o.addr, o.din, o.bcnt} !== {1'b0, 7'h50, 32'hA1B2C3D4, 2'd3}) begin
            errors++;
            $display("FAIL single_cmd got rw %0d addr %h din %h bcnt %0d exp 0 50 a1b2c3d4 3", o.rw, o.addr, o.din, o.bcnt);
        end
        ptr_m = 1;
    endtask

    task automatic test_launch_timeout();
        obs_t o;
        randomize_data();
        req1 = 1'b1;
        do_txn(100, 1, 1'b0, o);
        vectors++;
        if (o.en_cnt !== LCYC || o.busy_cyc !== 0) begin
            errors++;
            $display("FAIL launch_tmo_len got en %0d busy %0d exp %0d 0", o.en_cnt, o.busy_cyc, LCYC);
        end
        vectors++;
        if (o.pulses !== 16'h0001 || o.timed_out) begin
            errors++;
            $display("FAIL launch_tmo_err got %h tmo %0d exp 0001", o.pulses, o.timed_out);
        end
        vectors++;
        if ({gnt0, gnt1, m_enable} !== 3'b000) begin
            errors++;
            $display("FAIL launch_tmo_idle got %b exp 000", {gnt0, gnt1, m_enable});
        end
        ptr_m = 0;
    endtask

    task automatic test_busy_timeout();
        obs_t o;
        int   w;
        w = ptr_m;
        randomize_data();
        if (w == 0) req0 = 1'b1;
        else        req1 = 1'b1;
        do_txn(1, 100, 1'b0, o);
        vectors++;
        if (o.busy_cyc !== TMO || o.pulses !== model_pulses(0, w)) begin
            errors++;
            $display("FAIL busy_tmo got busy %0d pulses %h exp %0d %h", o.busy_cyc, o.pulses, TMO, model_pulses(0, w));
        end
        ptr_m = 1 - w;
        req0 = 1'b1;
        req1 = 1'b1;
        do_txn(1, 1, 1'b0, o);
        vectors++;
        if (o.first_gnt !== ptr_m) begin
            errors++;
            $display("FAIL busy_tmo_ptr got gnt%0d exp gnt%0d", o.first_gnt, ptr_m);
        end
        ptr_m = 1 - ptr_m;
        req0 = 1'b0;
        req1 = 1'b0;
    endtask

    task automatic test_drop_req();
        obs_t o;
        randomize_data();
        req1 = 1'b1;
        do_txn(2, 4, 1'b1, o);
        vectors++;
        if (o.first_gnt !== 1 || o.pulses !== 16'h0100 || o.timed_out) begin
            errors++;
            $display("FAIL drop_req got gnt%0d pulses %h tmo %0d exp gnt1 0100", o.first_gnt, o.pulses, o.timed_out);
        end
        vectors++;
        if (o.din !== din1 || o.addr !== addr1) begin
            errors++;
            $display("FAIL drop_req_cmd got %h %h exp %h %h", o.din, o.addr, din1, addr1);
        end
        ptr_m = 0;
    endtask

    task automatic test_reset_mid();
        obs_t o;
        bit   seen;
        randomize_data();
        req0 = 1'b1;
        do_txn(1, 1, 1'b0, o);
        ptr_m = 1;
        req0 = 1'b1;
        seen = 0;
        for (int i = 0; i < 10; i++) begin
            @(posedge clk);
            #1;
            if (m_enable) begin
                seen = 1;
                break;
            end
        end
        m_ready = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        vectors++;
        if (!seen || {gnt0, m_enable} !== 2'b10) begin
            errors++;
            $display("FAIL rst_mid_busy got seen %0d gnt0/en %b exp 1 10", seen, {gnt0, m_enable});
        end
        rst = 1'b0;
        @(posedge clk);
        #1;
        vectors++;
        if ({gnt0, gnt1, m_enable, done0, done1, err0, err1} !== 7'd0) begin
            errors++;
            $display("FAIL rst_mid_drop got %b exp 0000000", {gnt0, gnt1, m_enable, done0, done1, err0, err1});
        end
        rst = 1'b1;
        req0 = 1'b0;
        m_ready = 1'b1;
        ptr_m = 0;
        @(posedge clk);
        #1;
        vectors++;
        if ({done0, done1, err0, err1} !== 4'd0) begin
            errors++;
            $display("FAIL rst_mid_nopulse got %b exp 0000", {done0, done1, err0, err1});
        end
        randomize_data();
        req0 = 1'b1;
        req1 = 1'b1;
        do_txn(1, 2, 1'b0, o);
        vectors++;
        if (o.first_gnt !== 0 || o.pulses !== 16'h1000 || o.din !== din0) begin
            errors++;
            $display("FAIL rst_mid_after got gnt%0d pulses %h din %h exp gnt0 1000 %h", o.first_gnt, o.pulses, o.din, din0);
        end
        ptr_m = 1;
        req1 = 1'b0;
    endtask

    task automatic test_random();
        obs_t        o;
        int          r, lw, bl, win, exp_en, exp_busy;
        bit          ok;
        logic [31:0] exp_din;
        logic [6:0]  exp_addr;
        logic        exp_rw;
        logic [1:0]  exp_bcnt;
        for (int n = 0; n < 40; n++) begin
            randomize_data();
            r  = int'($urandom_range(1, 3));
            lw = int'($urandom_range(1, 10));
            bl = int'($urandom_range(1, 20));
            req0 = r[0];
            req1 = r[1];
            win      = model_winner(r[0], r[1], ptr_m);
            ok       = model_ok(lw, bl);
            exp_en   = (lw <= LCYC) ? lw : LCYC;
            exp_busy = (lw <= LCYC) ? ((bl <= TMO) ? bl : TMO) : 0;
            exp_din  = win ? din1 : din0;
            exp_addr = win ? addr1 : addr0;
            exp_rw   = win ? rw1 : rw0;
            exp_bcnt = win ? bcnt1 : bcnt0;
            do_txn(lw, bl, 1'($urandom_range(0, 1)), o);
            vectors++;
            if (o.first_gnt !== win || o.overlap || o.timed_out) begin
                errors++;
                $display("FAIL rnd_%0d_gnt got gnt%0d ovl %0d tmo %0d exp gnt%0d", n, o.first_gnt, o.overlap, o.timed_out, win);
            end
            vectors++;
            if (o.en_cnt !== exp_en || o.busy_cyc !== exp_busy) begin
                errors++;
                $display("FAIL rnd_%0d_len got en %0d busy %0d exp %0d %0d", n, o.en_cnt, o.busy_cyc, exp_en, exp_busy);
            end
            vectors++;
            if (o.pulses !== model_pulses(ok, win) || o.gnt_at_pulse) begin
                errors++;
                $display("FAIL rnd_%0d_pulse got %h gnt %0d exp %h", n, o.pulses, o.gnt_at_pulse, model_pulses(ok, win));
            end
            vectors++;
            if ({o.rw, o.addr, o.din, o.bcnt} !== {exp_rw, exp_addr, exp_din, exp_bcnt}) begin
                errors++;
                $display("FAIL rnd_%0d_cmd got %0d %h %h %0d exp %0d %h %h %0d", n, o.rw, o.addr, o.din, o.bcnt, exp_rw, exp_addr, exp_din, exp_bcnt);
            end
            ptr_m = 1 - win;
            req0 = 1'b0;
            req1 = 1'b0;
        end
    endtask

    initial begin
        test_reset();
        test_alternation();
        test_single_write();
        test_launch_timeout();
        test_busy_timeout();
        test_drop_req();
        test_reset_mid();
        test_random();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
        $finish;
    end

endmodule
